fifo_rd_packer: RTL and testbench

Read-side consumer of the asynchronous FIFO, clocked entirely in the read domain. Pops DSIZE-bit words via rinc/rempty/rdata, packs PACK consecutive words into one wide word, and presents it downstream on a valid/ready handshake. A flush request forces out a partial word. Sustains one pop per rclk when downstream never stalls.

---
 rtl/fifo_rd_pack_pkg.sv | 20 ++
 rtl/fifo_rd_pack_outreg.sv | 60 ++++++
 rtl/fifo_rd_packer.sv | 114 +++++++++++
 tb/tb_fifo_rd_packer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pack_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
package fifo_rd_pack_pkg;

   // Default FIFO word width and words per packed output word.
   localparam int DSIZE_DEF = 8;
   localparam int PACK_DEF  = 4;

   // FILL: popping and packing normally. FLUSH: a partial word is waiting
   // for the output slot.
   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_FLUSH = 1'b1
   } st_e;

   // Lane-zeroing helper: a lane is kept only if it lies below the fill count.
   function automatic logic lane_live(input int unsigned lane, input int unsigned n);
      return (lane < n);
   endfunction

endpackage

// File: rtl/fifo_rd_pack_outreg.sv
// Output register for the packer. Handshake: a word transfers on a rising
// edge where out_valid and out_ready are both high; once out_valid is high,
// out_data/out_cnt hold until that transfer, and out_valid only drops on it.
module fifo_rd_pack_outreg
   import fifo_rd_pack_pkg::*;
#(
   parameter int W  = 32,
   parameter int CW = 3
) (
   input  logic          rclk,
   input  logic          rrst_n,
   input  logic          load,
   input  logic [W-1:0]  load_data,
   input  logic [CW-1:0] load_cnt,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [W-1:0]  out_data,
   output logic [CW-1:0] out_cnt,
   output logic          slot_free
);

   logic          valid_q, valid_d;
   logic [W-1:0]  data_q, data_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The slot can take a new word if it is empty or is being drained this edge.
   assign slot_free = !valid_q || out_ready;

   // Load a new word, retire a transferred one, otherwise hold.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
         cnt_d   = load_cnt;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   // Output register state; cleared immediately by reset.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_cnt   = cnt_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-domain FIFO consumer: pops DSIZE-bit words from a show-ahead FIFO,
// packs PACK of them (first popped word in the low lane) and offers the
// packed word downstream. A flush pushes out a partial word with its lane
// count; lanes above the count are zero.
module fifo_rd_packer
   import fifo_rd_pack_pkg::*;
#(
   parameter  int DSIZE = DSIZE_DEF,
   parameter  int PACK  = PACK_DEF,
   localparam int CW    = $clog2(PACK + 1)
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic                  rempty,
   input  logic [DSIZE-1:0]      rdata,
   output logic                  rinc,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PACK*DSIZE-1:0] out_data,
   output logic [CW-1:0]         out_cnt,
   output st_e                   dbg_st
);

   localparam logic [CW-1:0] PACK_CW = CW'(PACK);

   logic [PACK-1:0][DSIZE-1:0] acc_q, acc_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   st_e                        st_q, st_d;

   logic                       slot_free;
   logic                       load;
   logic [PACK-1:0][DSIZE-1:0] load_lanes;
   logic [CW-1:0]              load_cnt;

   // Pop decision, lane fill, hand-off to the output register and flush FSM.
   always_comb begin
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      st_d       = st_q;
      rinc       = 1'b0;
      load       = 1'b0;
      load_lanes = '0;
      load_cnt   = '0;
      case (st_q)
         ST_FILL: begin
            if (flush) begin
               // Pops are frozen on the flush cycle; nothing to emit when empty.
               if (cnt_q != '0) st_d = ST_FLUSH;
            end else begin
               // A full accumulator can still pop if it empties into the slot now.
               rinc = rrst_n && !rempty && ((cnt_q < PACK_CW) || slot_free);
               if ((cnt_q == PACK_CW) && slot_free) begin
                  load       = 1'b1;
                  load_lanes = acc_q;
                  load_cnt   = PACK_CW;
                  cnt_d      = rinc ? CW'(1) : '0;
                  if (rinc) acc_d[0] = rdata;
               end else if (rinc) begin
                  for (int i = 0; i < PACK; i++) begin
                     if (cnt_q == CW'(i)) acc_d[i] = rdata;
                  end
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_FLUSH: begin
            // Stale lanes above the fill count are zeroed on the way out.
            if (slot_free) begin
               load = 1'b1;
               for (int i = 0; i < PACK; i++) begin
                  load_lanes[i] = lane_live(32'(i), 32'(cnt_q)) ? acc_q[i] : '0;
               end
               load_cnt = cnt_q;
               cnt_d    = '0;
               st_d     = ST_FILL;
            end
         end
         default: st_d = ST_FILL;
      endcase
   end

   // Accumulator, fill count and state; partial data is dropped on reset.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
         st_q  <= ST_FILL;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         st_q  <= st_d;
      end
   end

   assign dbg_st = st_q;

   fifo_rd_pack_outreg #(
      .W  (PACK * DSIZE),
      .CW (CW)
   ) u_outreg (
      .rclk      (rclk),
      .rrst_n    (rrst_n),
      .load      (load),
      .load_data (load_lanes),
      .load_cnt  (load_cnt),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_cnt   (out_cnt),
      .slot_free (slot_free)
   );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a show-ahead FIFO model feeds the DUT, and a
// word-grouping reference model fills an expected queue of packed words.
module tb_fifo_rd_packer;
  import fifo_rd_pack_pkg::*;

  localparam int DSIZE = 8;
  localparam int PACK  = 4;
  localparam int CW    = $clog2(PACK + 1);
  localparam int W     = PACK * DSIZE;

  // ---------------- clock / reset ----------------
  logic rclk = 1'b0;
  logic rrst_n;
  always #5 rclk = ~rclk;

  logic          rempty;
  logic [7:0]    rdata;
  logic          rinc;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_cnt;
  st_e           dbg_st;

  fifo_rd_packer #(.DSIZE(DSIZE), .PACK(PACK)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .dbg_st    (dbg_st)
  );

  // ---------------- show-ahead FIFO model ----------------
  logic [7:0] fifo_mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       fifo_hold = 1'b0;
  logic       pop_s = 1'b0;

  assign rempty = fifo_hold || (wr_ptr == rd_ptr);
  assign rdata  = fifo_mem[rd_ptr & 255];

  always @(posedge rclk) if (pop_s) rd_ptr <= rd_ptr + 1;

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] expc_q[$];
  logic [7:0]    stage_q[$];

  task automatic emit_word();
    logic [W-1:0] d;
    d = '0;
    for (int i = 0; i < stage_q.size(); i++) d = d | (W'(stage_q[i]) << (DSIZE * i));
    exp_q.push_back(d);
    expc_q.push_back(CW'(stage_q.size()));
    stage_q.delete();
  endtask

  task automatic push_word(input logic [7:0] w);
    fifo_mem[wr_ptr & 255] = w;
    wr_ptr++;
    stage_q.push_back(w);
    if (stage_q.size() == PACK) emit_word();
  endtask

  task automatic model_flush();
    if (stage_q.size() > 0) emit_word();
  endtask

  // Monitor on the falling edge: pop tracking, handshake rules, scoreboard.
  int            pop_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_data;
  logic [CW-1:0] prev_cnt;

  always @(negedge rclk) begin
    pop_s = rinc;
    if (rinc === 1'b1) pop_cnt++;
    if (rempty) check("rinc_while_empty", rinc, 0);
    if (prev_stall && rrst_n) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, prev_data);
      check("hold_cnt", out_cnt, prev_cnt);
    end
    if (rrst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected observed=%0h expected=none", out_data);
      end else begin
        check("sb_data", out_data, exp_q.pop_front());
        check("sb_cnt", out_cnt, expc_q.pop_front());
      end
    end
    prev_stall = rrst_n && out_valid && !out_ready;
    prev_data  = out_data;
    prev_cnt   = out_cnt;
  end

  // ---------------- driver tasks ----------------
  logic rnd_mode = 1'b0;

  task automatic step();
    @(posedge rclk);
    #1;
    if (rnd_mode) begin
      out_ready = 1'($urandom_range(0, 1));
      fifo_hold = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic sample();
    @(negedge rclk);
    #1;
  endtask

  task automatic wait_drained(input int budget);
    int n = 0;
    while (rd_ptr != wr_ptr && n < budget) begin
      step();
      n++;
    end
    check("fifo_drained", wr_ptr - rd_ptr, 0);
  endtask

  task automatic wait_sb_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("sb_empty", exp_q.size(), 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int base;
    int n;
    for (int i = 0; i < 256; i++) fifo_mem[i] = '0;
    rrst_n    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    fifo_hold = 1'b0;

    // Reset with FIFO empty, then with a word available.
    step();
    sample();
    check("rst_rinc_empty", rinc, 0);
    check("rst_valid", out_valid, 0);
    step();
    push_word(8'h01);
    sample();
    check("rst_rinc_nonempty", rinc, 0);
    check("rst_data", out_data, 0);
    check("rst_cnt", out_cnt, 0);
    check("rst_state", dbg_st, ST_FILL);

    // First word: 01..04, output after edge 5.
    step();
    rrst_n = 1'b1;
    push_word(8'h02);
    push_word(8'h03);
    push_word(8'h04);
    base = pop_cnt;
    sample();
    check("first_pop", rinc, 1);
    repeat (4) sample();
    check("no_early_valid", out_valid, 0);
    sample();
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 32'h04030201);
    check("lat_cnt", out_cnt, 4);
    check("lat_pops", pop_cnt - base, 4);
    wait_sb_empty(20);

    // Downstream stall with a full accumulator behind the held word.
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) push_word(8'h11 + 8'(i));
    repeat (10) step();
    sample();
    check("stall_valid", out_valid, 1);
    check("stall_data", out_data, 32'h14131211);
    check("stall_rinc", rinc, 0);
    check("stall_left", wr_ptr - rd_ptr, 4);
    step();
    out_ready = 1'b1;
    wait_sb_empty(40);

    // Flush of a two-word partial, with a word arriving on the flush cycle.
    step();
    push_word(8'hAA);
    push_word(8'hBB);
    wait_drained(20);
    repeat (2) step();
    step();
    flush = 1'b1;
    model_flush();
    push_word(8'hCC);
    sample();
    check("flush_no_pop", rinc, 0);
    step();
    flush = 1'b0;
    sample();
    check("flush_state", dbg_st, ST_FLUSH);
    check("flush_state_no_pop", rinc, 0);
    step();
    sample();
    check("flush_valid", out_valid, 1);
    check("flush_data", out_data, 32'h0000BBAA);
    check("flush_cnt", out_cnt, 2);

    // Flush with nothing accumulated produces no word.
    push_word(8'hDD);
    push_word(8'hEE);
    push_word(8'hFF);
    wait_sb_empty(30);
    repeat (2) step();
    step();
    flush = 1'b1;
    model_flush();
    step();
    flush = 1'b0;
    sample();
    check("empty_flush_state", dbg_st, ST_FILL);
    repeat (3) begin
      sample();
      check("empty_flush_no_valid", out_valid, 0);
    end

    // Reset mid-operation with a held word and three lanes accumulated.
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) push_word(8'($urandom_range(0, 255)));
    repeat (10) step();
    sample();
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_drained", wr_ptr - rd_ptr, 0);
    step();
    rrst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_cnt", out_cnt, 0);
    check("mid_rst_rinc", rinc, 0);
    exp_q.delete();
    expc_q.delete();
    stage_q.delete();
    repeat (2) step();
    step();
    rrst_n    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'($urandom_range(0, 255)));
    wait_sb_empty(20);

    // Random bursts with FIFO gaps, random backpressure and occasional flushes.
    rnd_mode = 1'b1;
    for (int b = 0; b < 25; b++) begin
      n = $urandom_range(1, 11);
      for (int k = 0; k < n; k++) push_word(8'($urandom_range(0, 255)));
      wait_drained(200);
      if ($urandom_range(0, 1) == 1) begin
        step();
        flush = 1'b1;
        model_flush();
        step();
        flush = 1'b0;
      end
    end
    rnd_mode = 1'b0;
    step();
    out_ready = 1'b1;
    fifo_hold = 1'b0;
    step();
    flush = 1'b1;
    model_flush();
    step();
    flush = 1'b0;
    wait_sb_empty(100);
    repeat (3) step();
    check("total_pops", pop_cnt, wr_ptr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
